key_cond: RTL and testbench

// - Push-button conditioner that sits directly upstream of the watch core.
// - Takes the three raw active-low board keys (mode, select, increment) on the 10 kHz watch clock.
// - Synchronises and debounces each key.
// - Emits clean one-cycle press pulses that drive the core's imode / iselhm / inc inputs.
// - Optionally auto-repeats the increment key while it is held, for fast alarm/time setting.

---
 rtl/key_cond.sv | 151 +++++++++++++++
 tb/tb_key_cond.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_cond.sv
// Push-button conditioner: 2-flop sync, per-key debounce, one-cycle press pulses.
// Optional inc auto-repeat FSM, built only when KEY_AUTOREPEAT_EN is defined.
module key_cond #(
  parameter int CW      = 16,
  parameter int DB_CNT  = 200,
  parameter int RPT_DLY = 5000,
  parameter int RPT_PER = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_mode_n,
  input  logic key_sel_n,
  input  logic key_inc_n,
  output logic mode_p,
  output logic sel_p,
  output logic inc_p,
  output logic inc_held
);

  localparam logic [CW-1:0] DB_TC = CW'(DB_CNT - 1);
  localparam logic [CW-1:0] ONE   = CW'(1);

  // key index: 0 = mode, 1 = select, 2 = increment
  logic [2:0]    raw;
  logic [2:0]    s1_q, s2_q;
  logic [2:0]    db_q, db_d;
  logic [2:0]    pr_q, pr_d;
  logic [CW-1:0] dc_q [3];
  logic [CW-1:0] dc_d [3];

  assign raw = ~{key_inc_n, key_sel_n, key_mode_n};

  always_comb begin
    db_d = db_q;
    pr_d = '0;
    for (int k = 0; k < 3; k++) begin
      dc_d[k] = dc_q[k];
      if (s2_q[k] == db_q[k]) begin
        dc_d[k] = '0;
      end else if (dc_q[k] == DB_TC) begin
        db_d[k] = s2_q[k];
        dc_d[k] = '0;
        // s2 differs from db here, so s2 & ~db reduces to s2: pulse on press only
        pr_d[k] = s2_q[k];
      end else begin
        dc_d[k] = dc_q[k] + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      db_q <= '0;
      pr_q <= '0;
      for (int k = 0; k < 3; k++) begin
        dc_q[k] <= '0;
      end
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
      db_q <= db_d;
      pr_q <= pr_d;
      for (int k = 0; k < 3; k++) begin
        dc_q[k] <= dc_d[k];
      end
    end
  end

  assign mode_p   = pr_q[0];
  assign sel_p    = pr_q[1];
  assign inc_held = db_q[2];

`ifdef KEY_AUTOREPEAT_EN
  // state  | meaning
  // IDLE   | inc not debounced-held, waiting for a press pulse
  // DELAY  | inc held, counting the initial repeat delay
  // REPEAT | inc held, emitting a pulse every repeat period
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  localparam logic [CW-1:0] DLY_TC = CW'(RPT_DLY - 1);
  localparam logic [CW-1:0] PER_TC = CW'(RPT_PER - 1);

  rpt_state_e    st_q, st_d;
  logic [CW-1:0] hc_q, hc_d;
  logic          rpt_q, rpt_d;

  always_comb begin
    st_d  = st_q;
    hc_d  = hc_q;
    rpt_d = 1'b0;
    case (st_q)
      IDLE: begin
        if (pr_d[2]) begin
          st_d = DELAY;
          hc_d = '0;
        end
      end
      DELAY: begin
        if (!db_q[2]) begin
          st_d = IDLE;
          hc_d = '0;
        end else if (hc_q == DLY_TC) begin
          rpt_d = 1'b1;
          hc_d  = '0;
          st_d  = REPEAT;
        end else begin
          hc_d = hc_q + ONE;
        end
      end
      REPEAT: begin
        if (!db_q[2]) begin
          st_d = IDLE;
          hc_d = '0;
        end else if (hc_q == PER_TC) begin
          rpt_d = 1'b1;
          hc_d  = '0;
        end else begin
          hc_d = hc_q + ONE;
        end
      end
      default: begin
        st_d = IDLE;
        hc_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= IDLE;
      hc_q  <= '0;
      rpt_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      hc_q  <= hc_d;
      rpt_q <= rpt_d;
    end
  end

  assign inc_p = pr_q[2] | rpt_q;
`else
  assign inc_p = pr_q[2];
`endif

endmodule

// File: tb/tb_key_cond.sv
// Self-checking bench for key_cond (DB_CNT=4, RPT_DLY=20, RPT_PER=5), both builds.
// Reference model works on windows of synchronised samples and press-edge arithmetic.
module tb_key_cond;
  localparam int CW  = 16;
  localparam int DB  = 4;
  localparam int DLY = 20;
  localparam int PER = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_mode_n = 1'b1, key_sel_n = 1'b1, key_inc_n = 1'b1;
  logic mode_p, sel_p, inc_p, inc_held;

  int n_cmp = 0;
  int n_bad = 0;

  key_cond #(.CW(CW), .DB_CNT(DB), .RPT_DLY(DLY), .RPT_PER(PER)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_mode_n(key_mode_n), .key_sel_n(key_sel_n), .key_inc_n(key_inc_n),
    .mode_p(mode_p), .sel_p(sel_p), .inc_p(inc_p), .inc_held(inc_held)
  );

  always #5 clk = ~clk;

  // reference model state
  bit m_s1 [3];
  bit m_s2 [3];
  bit m_db [3];
  bit m_p  [3];
  bit m_hist [3][$];
  bit m_rpt;
  int m_press;
  int m_edge;

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_s1[k] = 1'b0; m_s2[k] = 1'b0; m_db[k] = 1'b0; m_p[k] = 1'b0;
      m_hist[k].delete();
    end
    m_rpt = 1'b0;
    m_press = -1;
    m_edge = 0;
  endtask

  // db flips once the last DB synchronised samples all disagree with it
  task automatic model_edge();
    bit raw [3];
    bit db_pre [3];
    bit flip;
    int d;
    raw[0] = ~key_mode_n; raw[1] = ~key_sel_n; raw[2] = ~key_inc_n;
    m_edge++;
    for (int k = 0; k < 3; k++) begin
      db_pre[k] = m_db[k];
      m_p[k] = 1'b0;
      m_hist[k].push_back(m_s2[k]);
      if (m_hist[k].size() > DB) void'(m_hist[k].pop_front());
      flip = (m_hist[k].size() == DB);
      foreach (m_hist[k][j]) if (m_hist[k][j] == m_db[k]) flip = 1'b0;
      if (flip) begin
        m_db[k] = ~m_db[k];
        m_p[k] = m_db[k];
        m_hist[k].delete();
      end
      m_s2[k] = m_s1[k];
      m_s1[k] = raw[k];
    end
    if (m_p[2]) m_press = m_edge;
    m_rpt = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
    if (db_pre[2] && m_press >= 0) begin
      d = m_edge - m_press;
      if (d >= DLY && ((d - DLY) % PER) == 0) m_rpt = 1'b1;
    end
`else
    d = 0;
`endif
  endtask

  function automatic logic [3:0] exp_vec();
    return {m_p[0], m_p[1], m_p[2] | m_rpt, m_db[2]};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic settle(input int n);
    key_mode_n = 1'b1; key_sel_n = 1'b1; key_inc_n = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      n_cmp++;
      if ({mode_p, sel_p, inc_p, inc_held} !== exp_vec()) begin
        n_bad++;
        $display("FAIL settle cyc %0d: got %b expected %b", i, {mode_p, sel_p, inc_p, inc_held}, exp_vec());
      end
    end
  endtask

  task automatic test_reset();
    model_reset();
    #12;
    n_cmp++;
    if ({mode_p, sel_p, inc_p, inc_held} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b expected 0000", {mode_p, sel_p, inc_p, inc_held});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    settle(8);
  endtask

  task automatic test_mode_press();
    int hits = 0;
    for (int rep = 0; rep < 2; rep++) begin
      key_mode_n = 1'b0;
      for (int i = 1; i <= 12; i++) begin
        tick();
        n_cmp++;
        if ({mode_p, sel_p, inc_p, inc_held} !== exp_vec()) begin
          n_bad++;
          $display("FAIL mode_model rep %0d edge %0d: got %b expected %b", rep, i, {mode_p, sel_p, inc_p, inc_held}, exp_vec());
        end
        n_cmp++;
        if ({mode_p, sel_p, inc_p} !== {(i == 6), 2'b00}) begin
          n_bad++;
          $display("FAIL mode_timing rep %0d edge %0d: got %b expected %b", rep, i, {mode_p, sel_p, inc_p}, {(i == 6), 2'b00});
        end
        if (mode_p) hits++;
      end
      key_mode_n = 1'b1;
      for (int i = 1; i <= 12; i++) begin
        tick();
        n_cmp++;
        if (mode_p !== 1'b0) begin
          n_bad++;
          $display("FAIL mode_release rep %0d edge %0d: got %b expected 0", rep, i, mode_p);
        end
      end
    end
    n_cmp++;
    if (hits !== 2) begin
      n_bad++;
      $display("FAIL mode_count: got %0d expected 2", hits);
    end
  endtask

  task automatic test_sel_bounce();
    int pat [5] = '{3, 2, 3, 2, 14};
    int hits = 0;
    for (int s = 0; s < 5; s++) begin
      key_sel_n = s[0];
      for (int i = 0; i < pat[s]; i++) begin
        tick();
        n_cmp++;
        if ({mode_p, sel_p, inc_p, inc_held} !== exp_vec()) begin
          n_bad++;
          $display("FAIL sel_model seg %0d cyc %0d: got %b expected %b", s, i, {mode_p, sel_p, inc_p, inc_held}, exp_vec());
        end
        if (sel_p) hits++;
        if (sel_p && s < 4) begin
          n_bad++;
          $display("FAIL sel_bounce seg %0d: got pulse expected none", s);
        end
      end
    end
    n_cmp++;
    if (hits !== 1) begin
      n_bad++;
      $display("FAIL sel_count: got %0d expected 1", hits);
    end
    settle(10);
  endtask

  task automatic test_simultaneous();
    key_mode_n = 1'b0; key_sel_n = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      n_cmp++;
      if ({mode_p, sel_p, inc_p, inc_held} !== exp_vec()) begin
        n_bad++;
        $display("FAIL simul_model edge %0d: got %b expected %b", i, {mode_p, sel_p, inc_p, inc_held}, exp_vec());
      end
      n_cmp++;
      if ({mode_p, sel_p} !== {(i == 6), (i == 6)}) begin
        n_bad++;
        $display("FAIL simul_timing edge %0d: got %b expected %b", i, {mode_p, sel_p}, {(i == 6), (i == 6)});
      end
    end
    settle(10);
  endtask

  task automatic test_inc_hold();
    int hits = 0;
    int want = 0;
    bit e_p;
    key_inc_n = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      if (i == 61) key_inc_n = 1'b1;
      tick();
`ifdef KEY_AUTOREPEAT_EN
      e_p = (i == 6) || (i >= 26 && i <= 66 && ((i - 26) % 5) == 0);
`else
      e_p = (i == 6);
`endif
      if (e_p) want++;
      if (inc_p) hits++;
      n_cmp++;
      if ({mode_p, sel_p, inc_p, inc_held} !== exp_vec()) begin
        n_bad++;
        $display("FAIL inc_model edge %0d: got %b expected %b", i, {mode_p, sel_p, inc_p, inc_held}, exp_vec());
      end
      n_cmp++;
      if ({inc_p, inc_held} !== {e_p, (i >= 6 && i < 66)}) begin
        n_bad++;
        $display("FAIL inc_timing edge %0d: got %b expected %b", i, {inc_p, inc_held}, {e_p, (i >= 6 && i < 66)});
      end
    end
    n_cmp++;
    if (hits !== want) begin
      n_bad++;
      $display("FAIL inc_count: got %0d expected %0d", hits, want);
    end
    settle(5);
  endtask

  task automatic test_reset_mid_press();
    key_mode_n = 1'b0; key_inc_n = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if ({mode_p, sel_p, inc_p, inc_held} !== 4'b0000) begin
      n_bad++;
      $display("FAIL rst_mid_outputs: got %b expected 0000", {mode_p, sel_p, inc_p, inc_held});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      n_cmp++;
      if ({mode_p, inc_p, inc_held} !== {(i == 6), (i == 6), (i >= 6)}) begin
        n_bad++;
        $display("FAIL rst_mid_repress edge %0d: got %b expected %b", i, {mode_p, inc_p, inc_held}, {(i == 6), (i == 6), (i >= 6)});
      end
    end
    settle(12);
  endtask

  task automatic test_random();
    int rem [3];
    bit prs [3];
    for (int k = 0; k < 3; k++) begin
      rem[k] = int'($urandom_range(1, 10));
      prs[k] = 1'b0;
    end
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < 3; k++) begin
        if (rem[k] == 0) begin
          prs[k] = ~prs[k];
          rem[k] = (k == 2 && prs[k]) ? int'($urandom_range(1, 45)) : int'($urandom_range(1, 9));
        end
        rem[k]--;
      end
      key_mode_n = ~prs[0]; key_sel_n = ~prs[1]; key_inc_n = ~prs[2];
      if (c == 400) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if ({mode_p, sel_p, inc_p, inc_held} !== 4'b0000) begin
          n_bad++;
          $display("FAIL rand_reset: got %b expected 0000", {mode_p, sel_p, inc_p, inc_held});
        end
        #2;
        rst_n = 1'b1;
      end
      tick();
      n_cmp++;
      if ({mode_p, sel_p, inc_p, inc_held} !== exp_vec()) begin
        n_bad++;
        $display("FAIL rand_model cyc %0d: got %b expected %b", c, {mode_p, sel_p, inc_p, inc_held}, exp_vec());
      end
    end
    settle(12);
  endtask

  initial begin
    test_reset();
    test_mode_press();
    test_sel_bounce();
    test_simultaneous();
    test_inc_hold();
    test_reset_mid_press();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
